// File: rtl/host_egress_arbiter.sv
// Strict-priority arbiter of TS and NTS descriptors onto the single host egress port.
// Optional macro HEA_NTS_GUARD_EN: i_guard_band holds off NTS grants ahead of a TS slot.
module host_egress_arbiter #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [12:0] iv_ts_descriptor,
  input  logic        i_ts_descriptor_wr,
  output logic        o_ts_descriptor_ack,
  input  logic [12:0] iv_nts_descriptor,
  input  logic        i_fifo_empty,
  output logic        o_nts_descriptor_rd,
  input  logic        i_guard_band,
  input  logic        i_host_outport_free,
  output logic [12:0] ov_descriptor,
  output logic        o_descriptor_wr,
  output logic        o_ts_grant_pulse,
  output logic        o_nts_grant_pulse,
  output logic        o_guard_block_pulse,
  output logic [1:0]  ov_arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  arb_state_t  r_state;
  logic [3:0]  r_gap_cnt;
  logic [12:0] r_desc;
  logic        r_desc_wr;
  logic        r_ts_ack;
  logic        r_nts_rd;
  logic        r_ts_grant;
  logic        r_nts_grant;
  logic        r_guard_block;
  logic        w_guard_blk;

`ifdef HEA_NTS_GUARD_EN
  assign w_guard_blk = i_guard_band;
`else
  logic w_unused_guard;
  assign w_guard_blk    = 1'b0;
  assign w_unused_guard = i_guard_band;
`endif

  // Pulses default low every cycle; the grant decision in IDLE raises them for the ISSUE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_gap_cnt     <= 4'd0;
      r_desc        <= 13'd0;
      r_desc_wr     <= 1'b0;
      r_ts_ack      <= 1'b0;
      r_nts_rd      <= 1'b0;
      r_ts_grant    <= 1'b0;
      r_nts_grant   <= 1'b0;
      r_guard_block <= 1'b0;
    end else begin
      r_desc_wr     <= 1'b0;
      r_ts_ack      <= 1'b0;
      r_nts_rd      <= 1'b0;
      r_ts_grant    <= 1'b0;
      r_nts_grant   <= 1'b0;
      r_guard_block <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_host_outport_free && i_ts_descriptor_wr) begin
            r_desc     <= iv_ts_descriptor;
            r_desc_wr  <= 1'b1;
            r_ts_ack   <= 1'b1;
            r_ts_grant <= 1'b1;
            r_state    <= ST_ISSUE;
          end else if (i_host_outport_free && !i_fifo_empty && !w_guard_blk) begin
            r_desc      <= iv_nts_descriptor;
            r_desc_wr   <= 1'b1;
            r_nts_rd    <= 1'b1;
            r_nts_grant <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (i_host_outport_free && !i_fifo_empty && w_guard_blk) begin
            r_guard_block <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_gap_cnt <= GAP_LOAD;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          // Requests are ignored here so host_tx has time to drop outport_free.
          if (r_gap_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ov_descriptor       = r_desc;
  assign o_descriptor_wr     = r_desc_wr;
  assign o_ts_descriptor_ack = r_ts_ack;
  assign o_nts_descriptor_rd = r_nts_rd;
  assign o_ts_grant_pulse    = r_ts_grant;
  assign o_nts_grant_pulse   = r_nts_grant;
  assign o_guard_block_pulse = r_guard_block;
  assign ov_arb_state        = r_state;

endmodule

// File: tb/tb_host_egress_arbiter.sv
// Directed bench for host_egress_arbiter: per-cycle vector table plus guard-band and reset sequences.
// Builds with or without HEA_NTS_GUARD_EN; the guard sequence expectations follow the macro.
module tb_host_egress_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [12:0] iv_ts_descriptor;
  logic        i_ts_descriptor_wr;
  logic        o_ts_descriptor_ack;
  logic [12:0] iv_nts_descriptor;
  logic        i_fifo_empty;
  logic        o_nts_descriptor_rd;
  logic        i_guard_band;
  logic        i_host_outport_free;
  logic [12:0] ov_descriptor;
  logic        o_descriptor_wr;
  logic        o_ts_grant_pulse;
  logic        o_nts_grant_pulse;
  logic        o_guard_block_pulse;
  logic [1:0]  ov_arb_state;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse groups {wr, ack, rd, ts_grant, nts_grant, guard_block}
  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_TS   = 6'b110100;
  localparam logic [5:0] P_NTS  = 6'b101010;

  typedef struct {
    logic        rst;
    logic        free;
    logic        ts_wr;
    logic [12:0] ts_d;
    logic        empty;
    logic [12:0] nts_d;
    logic        guard;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  host_egress_arbiter #(.GAP_CYCLES(2)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .iv_ts_descriptor    (iv_ts_descriptor),
    .i_ts_descriptor_wr  (i_ts_descriptor_wr),
    .o_ts_descriptor_ack (o_ts_descriptor_ack),
    .iv_nts_descriptor   (iv_nts_descriptor),
    .i_fifo_empty        (i_fifo_empty),
    .o_nts_descriptor_rd (o_nts_descriptor_rd),
    .i_guard_band        (i_guard_band),
    .i_host_outport_free (i_host_outport_free),
    .ov_descriptor       (ov_descriptor),
    .o_descriptor_wr     (o_descriptor_wr),
    .o_ts_grant_pulse    (o_ts_grant_pulse),
    .o_nts_grant_pulse   (o_nts_grant_pulse),
    .o_guard_block_pulse (o_guard_block_pulse),
    .ov_arb_state        (ov_arb_state)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  function automatic logic [20:0] ex(input logic [1:0] st, input logic [5:0] p, input logic [12:0] d);
    return {st, p, d};
  endfunction

  function automatic logic [20:0] dut_out();
    return {ov_arb_state, o_descriptor_wr, o_ts_descriptor_ack, o_nts_descriptor_rd,
            o_ts_grant_pulse, o_nts_grant_pulse, o_guard_block_pulse, ov_descriptor};
  endfunction

  // Driver tasks
  task automatic add(input logic rst, input logic free, input logic ts_wr, input logic [12:0] ts_d,
                     input logic empty, input logic [12:0] nts_d, input logic guard,
                     input logic [20:0] e);
    vec_t v;
    v.rst = rst; v.free = free; v.ts_wr = ts_wr; v.ts_d = ts_d;
    v.empty = empty; v.nts_d = nts_d; v.guard = guard; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic free, input logic ts_wr, input logic [12:0] ts_d,
                       input logic empty, input logic [12:0] nts_d, input logic guard);
    i_rst = rst; i_host_outport_free = free; i_ts_descriptor_wr = ts_wr;
    iv_ts_descriptor = ts_d; i_fifo_empty = empty; iv_nts_descriptor = nts_d; i_guard_band = guard;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [20:0] act, input logic [20:0] e);
    n_checks++;
    if (act !== e) begin
      n_errors++;
      $display("FAIL %s: actual st=%0d pulses=%b desc=%h, expected st=%0d pulses=%b desc=%h",
               name, act[20:19], act[18:13], act[12:0], e[20:19], e[18:13], e[12:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int e);
    n_checks++;
    if (act != e) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, e);
    end
  endtask

  int gbp_cnt;
  int wr_cnt;
  int first_wr;
  int lat;
  logic [12:0] first_desc;

  initial begin
    // Reset with every request active: outputs stay 0.
    add(1, 1, 1, 13'h0A5, 0, 13'h022, 1, ex(2'd0, P_NONE, 13'h000));
    add(1, 1, 1, 13'h0A5, 0, 13'h022, 1, ex(2'd0, P_NONE, 13'h000));
    add(1, 1, 1, 13'h0A5, 0, 13'h022, 1, ex(2'd0, P_NONE, 13'h000));
    // TS only; issue spacing of 4 cycles.
    add(0, 1, 1, 13'h0A5, 1, 13'h000, 0, ex(2'd1, P_TS,   13'h0A5));
    add(0, 1, 1, 13'h0A5, 1, 13'h000, 0, ex(2'd2, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h0A5, 1, 13'h000, 0, ex(2'd2, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h0A5, 1, 13'h000, 0, ex(2'd0, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h0A5, 1, 13'h000, 0, ex(2'd1, P_TS,   13'h0A5));
    // Simultaneous TS and NTS: TS first, then NTS after the gap.
    add(0, 1, 1, 13'h101, 0, 13'h022, 0, ex(2'd2, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h101, 0, 13'h022, 0, ex(2'd2, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h101, 0, 13'h022, 0, ex(2'd0, P_NONE, 13'h0A5));
    add(0, 1, 1, 13'h101, 0, 13'h022, 0, ex(2'd1, P_TS,   13'h101));
    add(0, 1, 0, 13'h101, 0, 13'h022, 0, ex(2'd2, P_NONE, 13'h101));
    add(0, 1, 0, 13'h101, 0, 13'h022, 0, ex(2'd2, P_NONE, 13'h101));
    add(0, 1, 0, 13'h101, 0, 13'h022, 0, ex(2'd0, P_NONE, 13'h101));
    add(0, 1, 0, 13'h101, 0, 13'h022, 0, ex(2'd1, P_NTS,  13'h022));
    add(0, 1, 0, 13'h000, 1, 13'h000, 0, ex(2'd2, P_NONE, 13'h022));
    add(0, 1, 0, 13'h000, 1, 13'h000, 0, ex(2'd2, P_NONE, 13'h022));
    add(0, 1, 0, 13'h000, 1, 13'h000, 0, ex(2'd0, P_NONE, 13'h022));
    // Port busy with both requests pending: nothing happens until free returns.
    add(0, 0, 1, 13'h1C3, 0, 13'h0F0, 0, ex(2'd0, P_NONE, 13'h022));
    add(0, 0, 1, 13'h1C3, 0, 13'h0F0, 0, ex(2'd0, P_NONE, 13'h022));
    add(0, 0, 1, 13'h1C3, 0, 13'h0F0, 0, ex(2'd0, P_NONE, 13'h022));
    add(0, 1, 1, 13'h1C3, 0, 13'h0F0, 0, ex(2'd1, P_TS,   13'h1C3));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].free, vecs[i].ts_wr, vecs[i].ts_d,
            vecs[i].empty, vecs[i].nts_d, vecs[i].guard);
      tick();
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Reset during GAP: back to IDLE, TS re-granted, FIFO head still delivered later.
    drive(0, 1, 1, 13'h1C3, 0, 13'h0F0, 0);
    tick();
    check("gap_entry", dut_out(), ex(2'd2, P_NONE, 13'h1C3));
    drive(1, 1, 1, 13'h1C3, 0, 13'h0F0, 0);
    tick();
    check("rst_in_gap", dut_out(), ex(2'd0, P_NONE, 13'h000));
    drive(0, 1, 1, 13'h1C3, 0, 13'h0F0, 0);
    tick();
    check("ts_regrant", dut_out(), ex(2'd1, P_TS, 13'h1C3));
    drive(0, 1, 0, 13'h000, 0, 13'h0F0, 0);
    tick(); tick(); tick();
    check("gap_done", dut_out(), ex(2'd0, P_NONE, 13'h1C3));
    tick();
    check("fifo_kept", dut_out(), ex(2'd1, P_NTS, 13'h0F0));
    drive(0, 1, 0, 13'h000, 1, 13'h000, 0);
    tick(); tick(); tick();
    check("idle_again", dut_out(), ex(2'd0, P_NONE, 13'h0F0));

    // Guard band held for 5 cycles with NTS waiting.
    gbp_cnt = 0; wr_cnt = 0; first_wr = -1; first_desc = 13'h000;
    drive(0, 1, 0, 13'h000, 0, 13'h055, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_guard_block_pulse) gbp_cnt++;
      if (o_descriptor_wr) begin
        if (first_wr < 0) begin
          first_wr   = i;
          first_desc = ov_descriptor;
        end
        wr_cnt++;
      end
    end
`ifdef HEA_NTS_GUARD_EN
    check_int("guard_pulses", gbp_cnt, 5);
    check_int("guard_grants", wr_cnt, 0);
    drive(0, 1, 0, 13'h000, 0, 13'h055, 0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (o_descriptor_wr) begin
        lat = k;
        break;
      end
    end
    check_int("guard_release_latency", lat, 1);
    check("guard_release_issue", dut_out(), ex(2'd1, P_NTS, 13'h055));
`else
    check_int("noguard_pulses", gbp_cnt, 0);
    check_int("noguard_grants", wr_cnt, 2);
    check_int("noguard_first_cycle", first_wr, 0);
    check_int("noguard_first_desc", int'(first_desc), int'(13'h055));
`endif
    drive(0, 1, 0, 13'h000, 1, 13'h000, 0);
    tick(); tick(); tick(); tick();
    check("final_idle", dut_out(), ex(2'd0, P_NONE, 13'h055));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
